reg_pipe: RTL and testbench

- Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit data, each with a valid bit, joined by a valid/ready handshake.
- Successor to the plain and reset-value register primitives: adds configurable width/depth, a per-stage reset value, bubble collapsing, synchronous flush and an occupancy count.
- Sits between producers and consumers wherever timing must be broken without losing back-pressure.

---
 rtl/reg_pkg.sv | 11 +
 rtl/reg_pipe_if.sv | 28 ++
 rtl/reg_pipe_stage.sv | 56 +++++
 rtl/reg_pipe.sv | 78 +++++++
 tb/tb_reg_pipe.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_pkg.sv
// Shared helpers for the reg_* register primitives.
package reg_pkg;

  // Width of an occupancy counter able to hold 0..depth; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth + 1);
    return (w < 1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// Valid/ready bus of reg_pipe: upstream port, downstream port, flush and occupancy.
interface reg_pipe_if
  import reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/reg_pipe_stage.sv
// One elastic register stage: valid bit plus data, ready passes through when empty.
module reg_pipe_stage #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               DATA_RESET  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             stage_ready,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  logic xfer;

  assign stage_ready = ~v | dn_ready;
  assign xfer        = up_valid & stage_ready & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= 1'b0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (xfer) begin
      v <= 1'b1;
    end else if (dn_ready) begin
      v <= 1'b0;
    end
  end

  // Data registers are optionally left without reset to save reset routing.
  generate
    if (DATA_RESET) begin : g_data_rst
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          d <= RESET_VALUE;
        end else if (flush) begin
          d <= RESET_VALUE;
        end else if (xfer) begin
          d <= up_data;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        if (xfer) begin
          d <= up_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline of DEPTH stages with bubble collapsing, flush and occupancy count.
module reg_pipe
  import reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               DATA_RESET  = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_pipe_if.slave    bus
);

  localparam int unsigned CW = cnt_width(DEPTH);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk;
      assign unused_clk    = clk;
      assign bus.out_data  = bus.in_data;
      assign bus.out_valid = bus.in_valid & ~bus.flush & reset_n;
      assign bus.in_ready  = bus.out_ready & ~bus.flush & reset_n;
      assign bus.count     = '0;
    end else begin : g_pipe
      logic [DEPTH-1:0] v;
      logic [WIDTH-1:0] d [DEPTH];
      logic [DEPTH:0]   sr;
      logic [CW-1:0]    cnt;

      assign sr[DEPTH] = bus.out_ready;

      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (i == 0) begin : g_head
          assign up_valid = bus.in_valid;
          assign up_data  = bus.in_data;
        end else begin : g_link
          assign up_valid = v[i-1];
          assign up_data  = d[i-1];
        end

        reg_pipe_stage #(
          .WIDTH       (WIDTH),
          .RESET_VALUE (RESET_VALUE),
          .DATA_RESET  (DATA_RESET)
        ) u_stage (
          .clk         (clk),
          .reset_n     (reset_n),
          .flush       (bus.flush),
          .up_valid    (up_valid),
          .up_data     (up_data),
          .dn_ready    (sr[i+1]),
          .stage_ready (sr[i]),
          .v           (v[i]),
          .d           (d[i])
        );
      end

      // Occupancy is the population count of stage valid bits.
      always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
          cnt = cnt + CW'(v[i]);
        end
      end

      // Stages clear their valid bits in reset, so the input must be gated explicitly.
      assign bus.in_ready  = sr[0] & ~bus.flush & reset_n;
      assign bus.out_valid = v[DEPTH-1];
      assign bus.out_data  = d[DEPTH-1];
      assign bus.count     = cnt;
    end
  endgenerate

endmodule

// File: tb/tb_reg_pipe.sv
// Randomised and directed checks of reg_pipe against a word/position queue model.
module tb_reg_pipe;
  import reg_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam logic [7:0]  RV = 8'hA5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_pipe_if #(.WIDTH(W), .DEPTH(D)) ifa ();
  reg_pipe_if #(.WIDTH(W), .DEPTH(D)) ifb ();
  reg_pipe_if #(.WIDTH(W), .DEPTH(0)) ifz ();

  assign ifb.flush     = ifa.flush;
  assign ifb.in_data   = ifa.in_data;
  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.out_ready = ifa.out_ready;

  reg_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV), .DATA_RESET(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  reg_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV), .DATA_RESET(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));
  reg_pipe #(.WIDTH(W), .DEPTH(0), .RESET_VALUE(RV), .DATA_RESET(1'b1)) u_dut_z (
    .clk(clk), .reset_n(reset_n), .bus(ifz));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered words in flight, each with the stage index it occupies.
  typedef struct {
    logic [7:0] data;
    int         pos;
  } word_t;

  word_t      mq[$];
  logic [7:0] m_last;

  function automatic void model_clear();
    mq.delete();
    m_last = RV;
  endfunction

  task automatic model_cycle();
    int  np[$];
    int  lim;
    int  s;
    bit  pop;
    bit  exp_ov;
    bit  exp_rdy;
    exp_ov = (mq.size() > 0) && (mq[0].pos == int'(D) - 1);
    pop    = exp_ov && (ifa.out_ready === 1'b1);
    s      = pop ? 1 : 0;
    lim    = int'(D) - 1;
    for (int k = s; k < mq.size(); k++) begin
      int p;
      p = mq[k].pos + 1;
      if (p > lim) p = lim;
      np.push_back(p);
      lim = p - 1;
    end
    exp_rdy = !ifa.flush && ((np.size() == 0) || (np[np.size()-1] >= 1));

    chk("a_in_ready",  32'(ifa.in_ready),  32'(exp_rdy));
    chk("a_out_valid", 32'(ifa.out_valid), 32'(exp_ov));
    chk("a_count",     32'(ifa.count),     32'(mq.size()));
    chk("a_out_data",  32'(ifa.out_data),  32'(m_last));
    chk("b_in_ready",  32'(ifb.in_ready),  32'(exp_rdy));
    chk("b_out_valid", 32'(ifb.out_valid), 32'(exp_ov));
    chk("b_count",     32'(ifb.count),     32'(mq.size()));
    if (exp_ov) chk("b_out_data", 32'(ifb.out_data), 32'(mq[0].data));

    if (ifa.flush) begin
      model_clear();
    end else begin
      word_t w;
      if (pop) void'(mq.pop_front());
      for (int k = 0; k < mq.size(); k++) mq[k].pos = np[k];
      if (ifa.in_valid && exp_rdy) begin
        w.data = ifa.in_data;
        w.pos  = 0;
        mq.push_back(w);
      end
      if (mq.size() > 0 && mq[0].pos == int'(D) - 1) m_last = mq[0].data;
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset_n) begin
      model_clear();
      chk("rst_a_valid", 32'(ifa.out_valid), 32'd0);
      chk("rst_a_ready", 32'(ifa.in_ready),  32'd0);
      chk("rst_a_count", 32'(ifa.count),     32'd0);
      chk("rst_a_data",  32'(ifa.out_data),  32'(RV));
      chk("rst_b_valid", 32'(ifb.out_valid), 32'd0);
      chk("rst_b_count", 32'(ifb.count),     32'd0);
    end else begin
      model_cycle();
    end
  end

  task automatic drive(input bit vld, input logic [7:0] dat, input bit ordy, input bit fl);
    @(negedge clk);
    ifa.in_valid  = vld;
    ifa.in_data   = dat;
    ifa.out_ready = ordy;
    ifa.flush     = fl;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    ifa.flush     = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_data   = 8'h00;
    ifa.out_ready = 1'b0;
    ifz.flush     = 1'b0;
    ifz.in_valid  = 1'b0;
    ifz.in_data   = 8'h00;
    ifz.out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("async_rst_data",  32'(ifa.out_data),  32'(RV));
    chk("async_rst_count", 32'(ifa.count),     32'd0);
    chk("async_rst_ready", 32'(ifa.in_ready),  32'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;

    // Unstalled stream 01..10: three-edge latency, one word per cycle
    drain();
    for (int k = 0; k <= 18; k++) begin
      drive(k < 16, 8'(k + 1), 1'b1, 1'b0);
      #3;
      if (k >= 3) begin
        chk("stream_valid", 32'(ifa.out_valid), 32'd1);
        chk("stream_data",  32'(ifa.out_data),  32'(k - 2));
      end
      if (k >= 3 && k <= 16) chk("stream_count", 32'(ifa.count), 32'd3);
    end

    // Full pipe: stalled, then one consume-and-accept cycle
    drain();
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    drive(1'b1, 8'h04, 1'b0, 1'b0);
    #3;
    chk("full_count", 32'(ifa.count),    32'd3);
    chk("full_ready", 32'(ifa.in_ready), 32'd0);
    chk("full_data",  32'(ifa.out_data), 32'h01);
    drive(1'b1, 8'h04, 1'b1, 1'b0);
    #3;
    chk("full_shift_ready", 32'(ifa.in_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk("full_shift_count", 32'(ifa.count),    32'd3);
    chk("full_shift_data",  32'(ifa.out_data), 32'h02);

    // Bubble collapse behind a stalled output
    drain();
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk("bubble_count1", 32'(ifa.count),     32'd1);
    chk("bubble_valid",  32'(ifa.out_valid), 32'd1);
    chk("bubble_data",   32'(ifa.out_data),  32'h55);
    chk("bubble_ready1", 32'(ifa.in_ready),  32'd1);
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    #3;
    chk("bubble_ready2", 32'(ifa.in_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk("bubble_count3", 32'(ifa.count),    32'd3);
    chk("bubble_ready3", 32'(ifa.in_ready), 32'd0);

    // Flush of a full pipe with an input word offered
    drive(1'b1, 8'h99, 1'b0, 1'b1);
    #3;
    chk("flush_ready", 32'(ifa.in_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk("flush_count",   32'(ifa.count),     32'd0);
    chk("flush_valid",   32'(ifa.out_valid), 32'd0);
    chk("flush_data_a",  32'(ifa.out_data),  32'(RV));
    chk("flush_data_b",  32'(ifb.out_data),  32'h55);
    chk("flush_count_b", 32'(ifb.count),     32'd0);

    // Zero-depth pass-through
    ifz.in_data   = 8'h3C;
    ifz.in_valid  = 1'b1;
    ifz.out_ready = 1'b0;
    #1;
    chk("d0_data",  32'(ifz.out_data),  32'h3C);
    chk("d0_valid", 32'(ifz.out_valid), 32'd1);
    chk("d0_ready", 32'(ifz.in_ready),  32'd0);
    chk("d0_count", 32'(ifz.count),     32'd0);
    ifz.out_ready = 1'b1;
    #1;
    chk("d0_ready_hi", 32'(ifz.in_ready), 32'd1);
    ifz.flush = 1'b1;
    #1;
    chk("d0_flush_valid", 32'(ifz.out_valid), 32'd0);
    chk("d0_flush_ready", 32'(ifz.in_ready),  32'd0);

    // Random traffic in phases of differing back-pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        bit vld, ordy, fl;
        vld  = ($urandom % 4) != 0;
        ordy = (ph == 1) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
        fl   = ($urandom % 40) == 0;
        drive(vld, 8'($urandom), ordy, fl);
      end
    end

    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
